// File: rtl/iopin_dir_sequencer.sv
// ---------------------------------------------------------------------------
// iopin_dir_sequencer
//
// Break-before-make controller for the 74LVC pin buffers (MOSI, CLOCK, MISO,
// CS, AUX). A whole-pin configuration (direction, open-drain, output level)
// arrives from the register file. It is applied so that the FPGA side (bufio,
// pin_oe) and the external buffer (bufdir) never drive the same net from both
// ends while a pin changes direction.
//
// When no pin changes direction, the new levels and open-drain selects are
// applied at once (fast path). Otherwise the block steps through these states:
//   ISOLATE : changing pins are released on the FPGA side, then wait
//   SWITCH  : buffer direction, open-drain and levels are updated
//   SETTLE  : wait for the buffer to turn around
//   ENABLE  : FPGA output enables follow the new directions
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-low reset; all pins become safe inputs
//   cfg_valid  a new configuration is offered
//   cfg_ready  the block accepts a configuration (high only in IDLE)
//   cfg_dir    requested direction per pin, 1 = output
//   cfg_od     requested open-drain enable per pin
//   cfg_dout   requested output level per pin
//   abort      synchronous emergency release of all pins
//   bufdir     buffer direction, 1 = buffer drives the pin
//   bufod      open-drain select to the buffer
//   pin_oe     the FPGA drives bufio toward the buffer
//   dout       level driven on bufio when pin_oe = 1
//   busy       a sequence is in progress
//   done       one-cycle pulse when a configuration is fully applied
//   aborted    one-cycle pulse when an abort is taken
// ---------------------------------------------------------------------------
module iopin_dir_sequencer #(
  parameter int NUM_PINS    = 5,
  parameter int DEAD_CYCLES = 4,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [NUM_PINS-1:0] cfg_dir,
  input  logic [NUM_PINS-1:0] cfg_od,
  input  logic [NUM_PINS-1:0] cfg_dout,
  input  logic                abort,
  output logic [NUM_PINS-1:0] bufdir,
  output logic [NUM_PINS-1:0] bufod,
  output logic [NUM_PINS-1:0] pin_oe,
  output logic [NUM_PINS-1:0] dout,
  output logic                busy,
  output logic                done,
  output logic                aborted
);

  typedef enum logic [2:0] {
    IDLE,
    ISOLATE,
    SWITCH,
    SETTLE,
    ENABLE
  } state_t;

  // The counter runs 0 .. DEAD_CYCLES-1, so each wait state lasts exactly
  // DEAD_CYCLES cycles.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEAD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [NUM_PINS-1:0]   bufdir_q, bufdir_d;
  logic [NUM_PINS-1:0]   bufod_q, bufod_d;
  logic [NUM_PINS-1:0]   pin_oe_q, pin_oe_d;
  logic [NUM_PINS-1:0]   dout_q, dout_d;
  logic [NUM_PINS-1:0]   tgt_dir_q, tgt_dir_d;
  logic [NUM_PINS-1:0]   tgt_od_q, tgt_od_d;
  logic [NUM_PINS-1:0]   tgt_dout_q, tgt_dout_d;
  logic                  done_q, done_d;
  logic                  aborted_q, aborted_d;
  logic [NUM_PINS-1:0]   chg;

  // Pins whose direction differs between the offered configuration and the
  // direction the buffer currently has.
  assign chg = cfg_dir ^ bufdir_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bufdir_q   <= '0;
      bufod_q    <= '0;
      pin_oe_q   <= '0;
      dout_q     <= '0;
      tgt_dir_q  <= '0;
      tgt_od_q   <= '0;
      tgt_dout_q <= '0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bufdir_q   <= bufdir_d;
      bufod_q    <= bufod_d;
      pin_oe_q   <= pin_oe_d;
      dout_q     <= dout_d;
      tgt_dir_q  <= tgt_dir_d;
      tgt_od_q   <= tgt_od_d;
      tgt_dout_q <= tgt_dout_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bufdir_d   = bufdir_q;
    bufod_d    = bufod_q;
    pin_oe_d   = pin_oe_q;
    dout_d     = dout_q;
    tgt_dir_d  = tgt_dir_q;
    tgt_od_d   = tgt_od_q;
    tgt_dout_d = tgt_dout_q;
    done_d     = 1'b0;
    aborted_d  = 1'b0;

    if (abort) begin
      // Emergency release. This overrides both the handshake and the
      // sequence, and it does not produce a done pulse.
      state_d   = IDLE;
      bufdir_d  = '0;
      bufod_d   = '0;
      pin_oe_d  = '0;
      dout_d    = '0;
      aborted_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (cfg_valid) begin
            tgt_dir_d  = cfg_dir;
            tgt_od_d   = cfg_od;
            tgt_dout_d = cfg_dout;
            if (chg == '0) begin
              // No direction flips, so nothing can fight: apply at once.
              bufod_d  = cfg_od;
              dout_d   = cfg_dout;
              pin_oe_d = cfg_dir;
              done_d   = 1'b1;
            end else begin
              // Release only the pins that turn around. Unchanged pins keep
              // driving through the whole sequence.
              pin_oe_d = pin_oe_q & ~chg;
              cnt_d    = '0;
              state_d  = ISOLATE;
            end
          end
        end

        ISOLATE: begin
          if (cnt_q >= CNT_LAST) begin
            state_d = SWITCH;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        SWITCH: begin
          bufdir_d = tgt_dir_q;
          bufod_d  = tgt_od_q;
          dout_d   = tgt_dout_q;
          cnt_d    = '0;
          state_d  = SETTLE;
        end

        SETTLE: begin
          if (cnt_q >= CNT_LAST) begin
            // done is registered, so it is high for exactly the ENABLE cycle.
            state_d = ENABLE;
            done_d  = 1'b1;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        ENABLE: begin
          pin_oe_d = tgt_dir_q;
          state_d  = IDLE;
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign cfg_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign bufdir    = bufdir_q;
  assign bufod     = bufod_q;
  assign pin_oe    = pin_oe_q;
  assign dout      = dout_q;
  assign done      = done_q;
  assign aborted   = aborted_q;

  // The FPGA may only drive a pin whose buffer is also pointed outward.
  oe_implies_dir_a : assert property (@(posedge clk) disable iff (!rst)
    (pin_oe_q & ~bufdir_q) == '0);

  // The buffer direction must not flip under an active FPGA driver. Abort is
  // excluded because it releases both sides at the same edge.
  no_flip_while_driven_a : assert property (@(posedge clk) disable iff (!rst)
    !abort |-> (((bufdir_d ^ bufdir_q) & pin_oe_q) == '0));

  never_done_and_aborted_a : assert property (@(posedge clk) disable iff (!rst)
    !(done_q && aborted_q));

endmodule

// File: doc/iopin_dir_sequencer.md
Name: iopin_dir_sequencer

Overview:
Break-before-make controller for the 74LVC pin buffers (MOSI, CLOCK, MISO, CS, AUX).
- Accepts a whole-pin configuration (direction, open-drain, output level) from the MCU register file.
- Applies the configuration so the FPGA and the external buffer never drive against each other during a direction change.
- Sits between the register file (0x19 pin-config writes) and the bufdir/bufod/bufio drivers.

Parameters:
NUM_PINS, 5, number of buffered I/O pins sequenced together
DEAD_CYCLES, 4, clk cycles of isolation before and after a direction flip; legal range 1..255
CNT_WIDTH, 8, width of the dead-time counter; must hold DEAD_CYCLES

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
cfg_valid  in  1  new configuration offered
cfg_ready  out  1  block can accept a configuration
cfg_dir  in  NUM_PINS  requested direction per pin, 1 = output
cfg_od  in  NUM_PINS  requested open-drain enable per pin
cfg_dout  in  NUM_PINS  requested output level per pin
abort  in  1  synchronous emergency release of all pins
bufdir  out  NUM_PINS  buffer direction, 1 = buffer drives pin
bufod  out  NUM_PINS  open-drain select to buffer
pin_oe  out  NUM_PINS  FPGA drives bufio toward buffer
dout  out  NUM_PINS  level driven on bufio when pin_oe = 1
busy  out  1  sequence in progress (state != IDLE)
done  out  1  one-cycle pulse, configuration fully applied
aborted  out  1  one-cycle pulse, abort taken

Behaviour:
Reset (rst = 0): all pins become safe inputs.
- bufdir, bufod, pin_oe, dout = 0; busy, done, aborted = 0; cfg_ready = 1; state IDLE.

Handshake:
- cfg_ready = 1 only in IDLE.
- Transfer occurs on an edge where cfg_valid & cfg_ready; the cfg_* vectors are captured at that edge.
- cfg_valid while busy is ignored; there is no queueing.

Change mask: chg = cfg_dir XOR current bufdir, computed at accept.

Fast path (chg == 0):
- At the accept edge, bufod <= cfg_od and dout <= cfg_dout.
- pin_oe <= cfg_dir.
- done = 1 in the following cycle; state stays IDLE; cfg_ready stays 1.

Sequenced path (chg != 0). States are IDLE, ISOLATE, SWITCH, SETTLE, ENABLE.
- Accept edge: state <= ISOLATE; pin_oe[i] <= 0 for chg[i]. Unchanged pins keep their old pin_oe/bufod/dout. Counter <= 0.
- ISOLATE: lasts exactly DEAD_CYCLES cycles, then goes to SWITCH.
- SWITCH: lasts 1 cycle. On the exit edge, bufdir <= cfg_dir, bufod <= cfg_od, dout <= cfg_dout (all pins). Counter <= 0.
- SETTLE: lasts DEAD_CYCLES cycles, then goes to ENABLE.
- ENABLE: lasts 1 cycle. On the exit edge, pin_oe <= cfg_dir and state <= IDLE. done = 1 during the ENABLE cycle.
- Latency: done is high 2*DEAD_CYCLES+1 cycles after the accept edge. cfg_ready returns the cycle after ENABLE.

Invariants (checked by assertion):
- A pin with pin_oe = 1 always has bufdir = 1.
- A changing pin never has bufdir toggle while pin_oe = 1.

Abort:
- Sampled at any edge in any state; takes priority over cfg_valid and over state progression.
- Next state: pin_oe = 0, bufdir = 0, bufod = 0, dout = 0, state IDLE, aborted = 1 for one cycle.
- No done pulse for the interrupted sequence.
- Abort in IDLE also clears all pins.

Other rules:
- busy = (state != IDLE).
- done and aborted are never high together.
- The counter saturates and is ignored outside ISOLATE/SETTLE.
- Reset mid-sequence behaves as full reset; no done pulse.

Test Plan:
- Reset release: all outputs 0, cfg_ready = 1; offer cfg_dir=00001, od=0, dout=00001 -> ISOLATE 4 cycles, SWITCH 1, SETTLE 4; done 9 cycles after accept; bufdir=00001 set at the SWITCH exit edge, pin_oe=00001 set at the ENABLE exit edge.
- Fast path: with bufdir=00001, offer dir=00001, dout=00000, od=00001 -> dout/bufod update at the accept edge, done next cycle, busy never asserted.
- Mixed change: current dir=00011, request dir=00110 -> pin_oe[0] and pin_oe[2] low during ISOLATE; pin1 keeps driving unchanged throughout; final pin_oe=00110; invariant never violated.
- Back-to-back: cfg_valid held high with a second config during busy -> ignored until cfg_ready; second transfer accepted the cycle after ENABLE, and its done follows after its own latency.
- Abort during SETTLE (cycle 7 of the sequence): next cycle all outputs = 0, aborted = 1, no done; cfg_ready = 1 the following cycle.
- Async reset asserted mid-ISOLATE: outputs clear immediately without a clock edge; after release the block accepts a new config normally.
